// File: rtl/apb_nn_result_fifo.sv
// rtl/apb_nn_result_fifo.sv - APB control/status slave with accelerator start/finish handshake and result FIFO
//
// Purpose:
//   Zero-wait-state APB slave that starts the NN accelerator, tracks its
//   run state, buffers its streamed results in a FIFO drained by a
//   pop-on-read register, and raises a level done interrupt.
//
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   PADDR/PWDATA/PWRITE   APB request (word index is PADDR[4:2])
//   PSEL/PENABLE          APB select/enable, access when both are high
//   PRDATA/PREADY/PSLVERR APB response (PREADY tied high)
//   acc_start_o           one-cycle start pulse to the accelerator
//   acc_data_i/valid_i    result stream into the FIFO
//   acc_ready_o           FIFO not full
//   acc_finish_i          one-cycle run-complete pulse
//   irq_o                 registered IRQ_EN & DONE
//
// Option:
//   NN_RESULT_PEEK_EN     adds a non-popping PEEK register at 0x10 and sets STATUS bit5.

module apb_nn_result_fifo #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_WIDTH      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      acc_start_o,
  input  logic [DATA_WIDTH-1:0]     acc_data_i,
  input  logic                      acc_valid_i,
  output logic                      acc_ready_o,
  input  logic                      acc_finish_i,
  output logic                      irq_o
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);

  localparam logic [2:0] IDX_CTRL   = 3'd0;
  localparam logic [2:0] IDX_STATUS = 3'd1;
  localparam logic [2:0] IDX_RESULT = 3'd2;
  localparam logic [2:0] IDX_PARAM  = 3'd3;
`ifdef NN_RESULT_PEEK_EN
  localparam logic [2:0] IDX_PEEK   = 3'd4;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic                   start_q, start_d;
  logic                   done_q, done_d;
  logic                   poperr_q, poperr_d;
  logic                   irq_en_q, irq_en_d;
  logic                   irq_q, irq_d;
  logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

  logic                   rd_access, wr_access;
  logic [2:0]             idx;
  logic                   fifo_empty, fifo_full;
  logic                   push, pop, pop_err, flush;
  logic                   start_req, done_clr, poperr_clr, ctrl_wr;
  logic [DATA_WIDTH-1:0]  head;
  logic [31:0]            rdata;
  logic                   slverr;
  logic                   unused_bits;

  assign idx       = PADDR[4:2];
  assign rd_access = PSEL & PENABLE & ~PWRITE;
  assign wr_access = PSEL & PENABLE & PWRITE;

  assign ctrl_wr    = wr_access && (idx == IDX_CTRL);
  assign start_req  = ctrl_wr && PWDATA[0];
  assign flush      = ctrl_wr && PWDATA[2];
  assign done_clr   = wr_access && (idx == IDX_STATUS) && PWDATA[1];
  assign poperr_clr = wr_access && (idx == IDX_STATUS) && PWDATA[2];

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_WIDTH'(FIFO_DEPTH));
  assign head       = mem_q[rd_ptr_q];

  // Ready comes only from registered occupancy, so a same-cycle pop on a
  // full FIFO cannot make room for a push until the next cycle.
  assign acc_ready_o = ~fifo_full;
  // A flush in the same cycle discards the incoming beat.
  assign push    = acc_valid_i & acc_ready_o & ~flush;
  assign pop     = rd_access && (idx == IDX_RESULT) && !fifo_empty;
  assign pop_err = rd_access && (idx == IDX_RESULT) && fifo_empty;

  assign unused_bits = ^{PWDATA[31:3], PADDR[APB_ADDR_WIDTH-1:5], PADDR[1:0]};

  // Run-state machine and sticky status bits.
  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    done_d   = done_q;
    poperr_d = poperr_q;
    irq_en_d = irq_en_q;

    if (done_clr)   done_d   = 1'b0;
    if (poperr_clr) poperr_d = 1'b0;
    if (pop_err)    poperr_d = 1'b1;
    if (ctrl_wr)    irq_en_d = PWDATA[1];

    if (state_q == S_IDLE) begin
      if (start_req) begin
        state_d = S_RUN;
        start_d = 1'b1;
        done_d  = 1'b0;
      end
    end else begin
      if (acc_finish_i) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    irq_d = irq_en_q & done_q;
  end

  // FIFO pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_WIDTH'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_WIDTH'(1);
        2'b01:   count_d = count_q - CNT_WIDTH'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      poperr_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      done_q   <= done_d;
      poperr_q <= poperr_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines which entries are valid.
  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= acc_data_i;
  end

  // Read mux: only drives data during the access phase.
  always_comb begin
    rdata  = '0;
    slverr = 1'b0;
    if (rd_access) begin
      case (idx)
        IDX_CTRL: rdata[1] = irq_en_q;
        IDX_STATUS: begin
          rdata[0] = (state_q == S_RUN);
          rdata[1] = done_q;
          rdata[2] = poperr_q;
          rdata[3] = fifo_empty;
          rdata[4] = fifo_full;
`ifdef NN_RESULT_PEEK_EN
          rdata[5] = 1'b1;
`endif
          rdata[8 +: CNT_WIDTH] = count_q;
        end
        IDX_RESULT: begin
          if (fifo_empty) slverr = 1'b1;
          else            rdata[DATA_WIDTH-1:0] = head;
        end
        IDX_PARAM: begin
          rdata[15:0]  = 16'(FIFO_DEPTH);
          rdata[23:16] = 8'(DATA_WIDTH);
        end
`ifdef NN_RESULT_PEEK_EN
        IDX_PEEK: begin
          if (!fifo_empty) rdata[DATA_WIDTH-1:0] = head;
        end
`endif
        default: rdata = '0;
      endcase
    end
  end

  assign PRDATA      = rdata;
  assign PSLVERR     = slverr;
  assign PREADY      = 1'b1;
  assign acc_start_o = start_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_apb_nn_result_fifo.sv
// tb/tb_apb_nn_result_fifo.sv - self-checking bench for apb_nn_result_fifo

module tb_apb_nn_result_fifo;

  localparam int DEPTH = 8;
`ifdef NN_RESULT_PEEK_EN
  localparam logic [31:0] FEAT = 32'h20;
`else
  localparam logic [31:0] FEAT = 32'h0;
`endif

  logic        HCLK, HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        acc_start_o;
  logic [31:0] acc_data_i;
  logic        acc_valid_i, acc_ready_o, acc_finish_i, irq_o;

  apb_nn_result_fifo dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .acc_start_o(acc_start_o),
    .acc_data_i(acc_data_i), .acc_valid_i(acc_valid_i), .acc_ready_o(acc_ready_o),
    .acc_finish_i(acc_finish_i), .irq_o(irq_o)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int checks = 0;
  int failures = 0;
  int start_pulses = 0;
  logic [31:0] sb[$];
  bit busy_m, done_m, perr_m;

  always @(posedge HCLK) if (acc_start_o) start_pulses <= start_pulses + 1;

  typedef struct {
    bit          wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;
  vec_t vecs[18];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] st(bit busy, bit done, bit perr, int cnt);
    logic [31:0] r;
    r = FEAT;
    r[0] = busy;
    r[1] = done;
    r[2] = perr;
    r[3] = (cnt == 0);
    r[4] = (cnt == DEPTH);
    r[15:8] = 8'(cnt);
    return r;
  endfunction

  task automatic apb_access(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                            input bit push_en, input logic [31:0] push_data,
                            output logic [31:0] rdata, output logic err);
    @(negedge HCLK);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(negedge HCLK);
    PENABLE = 1'b1;
    if (push_en) begin
      acc_valid_i = 1'b1;
      acc_data_i  = push_data;
    end
    #1;
    rdata = PRDATA;
    err   = PSLVERR;
    @(posedge HCLK);
    #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    if (push_en) acc_valid_i = 1'b0;
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    logic [31:0] d;
    logic e;
    apb_access(1'b1, addr, data, 1'b0, 32'h0, d, e);
  endtask

  task automatic rd_check(string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic e;
    apb_access(1'b0, addr, 32'h0, 1'b0, 32'h0, d, e);
    check(name, d, exp);
  endtask

  task automatic status_check(string name);
    rd_check(name, 12'h004, st(busy_m, done_m, perr_m, sb.size()));
  endtask

  task automatic push_one(input logic [31:0] v);
    @(negedge HCLK);
    check("push_ready", 32'(acc_ready_o), 32'(sb.size() < DEPTH));
    acc_valid_i = 1'b1;
    acc_data_i  = v;
    @(posedge HCLK);
    #1;
    acc_valid_i = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(v);
  endtask

  task automatic drain_one(string name);
    logic [31:0] d;
    logic e;
    logic [31:0] exp;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s scoreboard empty actual=0 expected=1", name);
    end else begin
      exp = sb.pop_front();
      apb_access(1'b0, 12'h008, 32'h0, 1'b0, 32'h0, d, e);
      check(name, d, exp);
      check({name, "_err"}, 32'(e), 32'h0);
    end
  endtask

  task automatic finish_pulse();
    @(negedge HCLK);
    acc_finish_i = 1'b1;
    @(negedge HCLK);
    acc_finish_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic e;
    int p0;

    HRESETn = 1'b0; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    acc_data_i = '0; acc_valid_i = 1'b0; acc_finish_i = 1'b0;
    busy_m = 0; done_m = 0; perr_m = 0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    check("rst_ready", 32'(acc_ready_o), 32'h1);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_start", 32'(acc_start_o), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    check("pready", 32'(PREADY), 32'h1);

    vecs[0]  = '{1'b0, 12'h000, 32'h0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 12'h004, 32'h0, FEAT | 32'h8, 1'b0};
    vecs[2]  = '{1'b0, 12'h00C, 32'h0, 32'h0020_0008, 1'b0};
    vecs[3]  = '{1'b0, 12'h010, 32'h0, 32'h0, 1'b0};
    vecs[4]  = '{1'b0, 12'h014, 32'h0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 12'h01C, 32'h0, 32'h0, 1'b0};
    vecs[6]  = '{1'b0, 12'h008, 32'h0, 32'h0, 1'b1};
    vecs[7]  = '{1'b0, 12'h004, 32'h0, FEAT | 32'hC, 1'b0};
    vecs[8]  = '{1'b1, 12'h004, 32'h4, 32'h0, 1'b0};
    vecs[9]  = '{1'b0, 12'h004, 32'h0, FEAT | 32'h8, 1'b0};
    vecs[10] = '{1'b1, 12'h00C, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[11] = '{1'b0, 12'h00C, 32'h0, 32'h0020_0008, 1'b0};
    vecs[12] = '{1'b1, 12'h000, 32'h2, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 12'h000, 32'h0, 32'h2, 1'b0};
    vecs[14] = '{1'b1, 12'h014, 32'hFFFF_FFFF, 32'h0, 1'b0};
    vecs[15] = '{1'b0, 12'h000, 32'h0, 32'h2, 1'b0};
    vecs[16] = '{1'b1, 12'h000, 32'h0, 32'h0, 1'b0};
    vecs[17] = '{1'b0, 12'h000, 32'h0, 32'h0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      apb_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 32'h0, d, e);
      if (!vecs[i].wr) begin
        check($sformatf("vec%0d_rdata", i), d, vecs[i].exp);
        check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].exp_err));
      end
    end
    check("no_start_from_ctrl", 32'(start_pulses), 32'h0);

    // Start / finish / interrupt.
    wr(12'h000, 32'h3);
    busy_m = 1;
    check("start_pulse_hi", 32'(acc_start_o), 32'h1);
    @(posedge HCLK); #1;
    check("start_pulse_lo", 32'(acc_start_o), 32'h0);
    check("start_count1", 32'(start_pulses), 32'h1);
    status_check("status_busy");
    wr(12'h000, 32'h3);
    repeat (2) @(posedge HCLK);
    #1;
    check("no_second_start", 32'(start_pulses), 32'h1);
    finish_pulse();
    busy_m = 0; done_m = 1;
    check("irq_delay", 32'(irq_o), 32'h0);
    @(posedge HCLK); #1;
    check("irq_set", 32'(irq_o), 32'h1);
    rd_check("status_done", 12'h004, FEAT | 32'h0A);
    wr(12'h004, 32'h2);
    done_m = 0;
    @(posedge HCLK); #1;
    check("irq_cleared", 32'(irq_o), 32'h0);
    finish_pulse();
    status_check("finish_in_idle");
    check("irq_idle_finish", 32'(irq_o), 32'h0);

    // Fill, hold-off when full, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      push_one(32'h11 + i);
      status_check($sformatf("fill_status%0d", i));
    end
    @(negedge HCLK);
    acc_valid_i = 1'b1;
    acc_data_i  = 32'h19;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("full_holdoff", 32'(acc_ready_o), 32'h0);
    end
    acc_valid_i = 1'b0;
    status_check("full_status");
    for (int i = 0; i < DEPTH; i++) begin
      drain_one($sformatf("drain%0d", i));
      status_check($sformatf("drain_status%0d", i));
    end
    push_one(32'h19);
    drain_one("ninth");

    // Empty read with simultaneous push.
    apb_access(1'b0, 12'h008, 32'h0, 1'b1, 32'h77, d, e);
    check("empty_pop_data", d, 32'h0);
    check("empty_pop_err", 32'(e), 32'h1);
    sb.push_back(32'h77);
    perr_m = 1;
    status_check("empty_push_status");
    wr(12'h004, 32'h4);
    perr_m = 0;
    status_check("poperr_cleared");
    drain_one("empty_push_value");

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) push_one(32'h21 + i);
    @(negedge HCLK);
    acc_valid_i = 1'b1;
    acc_data_i  = 32'hA0;
    apb_access(1'b0, 12'h008, 32'h0, 1'b0, 32'h0, d, e);
    check("full_pop_data", d, sb.pop_front());
    check("full_pop_ready", 32'(acc_ready_o), 32'h1);
    @(posedge HCLK); #1;
    acc_valid_i = 1'b0;
    sb.push_back(32'hA0);
    status_check("full_pop_refill");
    for (int i = 0; i < DEPTH; i++) drain_one("full_pop_drain");

    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < DEPTH; i++) push_one(32'h40 + p * 16 + i);
      for (int i = 0; i < DEPTH; i++) drain_one($sformatf("wrap%0d_%0d", p, i));
    end

    // Flush during RUN, with a push in the flush cycle.
    p0 = start_pulses;
    wr(12'h000, 32'h3);
    busy_m = 1; done_m = 0;
    for (int i = 0; i < 5; i++) push_one(32'h51 + i);
    apb_access(1'b1, 12'h000, 32'h6, 1'b1, 32'h99, d, e);
    sb.delete();
    status_check("flush_status");
    check("flush_start_count", 32'(start_pulses - p0), 32'h1);

    push_one(32'hAB);
`ifdef NN_RESULT_PEEK_EN
    rd_check("peek1", 12'h010, 32'hAB);
    rd_check("peek2", 12'h010, 32'hAB);
`else
    rd_check("peek_unmapped", 12'h010, 32'h0);
`endif
    status_check("peek_count");
    drain_one("after_peek");

    finish_pulse();
    busy_m = 0; done_m = 1;
    status_check("run2_done");
    @(posedge HCLK); #1;
    check("irq_run2", 32'(irq_o), 32'h1);

    // Reset in the middle of a run with a full FIFO.
    wr(12'h000, 32'h3);
    for (int i = 0; i < DEPTH; i++) push_one(32'h61 + i);
    @(negedge HCLK);
    check("pre_reset_full", 32'(acc_ready_o), 32'h0);
    HRESETn = 1'b0;
    #1;
    check("async_rst_ready", 32'(acc_ready_o), 32'h1);
    check("async_rst_irq", 32'(irq_o), 32'h0);
    check("async_rst_start", 32'(acc_start_o), 32'h0);
    sb.delete();
    busy_m = 0; done_m = 0; perr_m = 0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    status_check("post_reset_status");
    rd_check("post_reset_ctrl", 12'h000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
